inst_fetch_unit: RTL

//  Decoupled RV32I instruction fetch stage directly upstream of the KLP32 decode/execute datapath.

---
 rtl/klp32_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/inst_fetch_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/klp32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : klp32_pkg
//  Description : Shared KLP32 types and constants for the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package klp32_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   typedef logic [XLEN-1:0] word_t;

   typedef struct packed {
      word_t inst;
      word_t pc;
   } fetch_entry_t;

   // Fetch status FSM encoding
   typedef logic [1:0] fetch_state_t;
   localparam logic [1:0] FS_RESET = 2'd0;
   localparam logic [1:0] FS_RUN   = 2'd1;
   localparam logic [1:0] FS_FLUSH = 2'd2;

   localparam word_t PC_STEP = 32'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous FIFO with flush; wrap-bit pointers, any DEPTH>=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
   import klp32_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = fetch_entry_t
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  T                             pushData,
   input  logic                         pop,
   input  logic                         flush,
   output T                             popData,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   T              r_mem [DEPTH];
   logic [AW:0]   r_wrPtr;
   logic [AW:0]   r_rdPtr;
   logic [AW-1:0] w_wrIdx;
   logic [AW-1:0] w_rdIdx;

   // Explicit wrap keeps the pointers correct for non-power-of-two depths
   function automatic logic [AW:0] ptrInc(input logic [AW:0] p);
      logic [AW:0] n;
      if (32'(p[AW-1:0]) == 32'(DEPTH - 1)) n = {~p[AW], {AW{1'b0}}};
      else                                  n = p + {{AW{1'b0}}, 1'b1};
      return n;
   endfunction

   assign w_wrIdx = r_wrPtr[AW-1:0];
   assign w_rdIdx = r_rdPtr[AW-1:0];
   assign empty   = (r_wrPtr == r_rdPtr);
   assign full    = (r_wrPtr[AW] != r_rdPtr[AW]) && (w_wrIdx == w_rdIdx);
   assign count   = (r_wrPtr[AW] == r_rdPtr[AW]) ?
                    CW'(32'(w_wrIdx) - 32'(w_rdIdx)) :
                    CW'(32'(DEPTH) - 32'(w_rdIdx) + 32'(w_wrIdx));
   assign popData = empty ? '0 : r_mem[w_rdIdx];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else if (flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (push) r_wrPtr <= ptrInc(r_wrPtr);
         if (pop)  r_rdPtr <= ptrInc(r_rdPtr);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) r_mem[w_wrIdx] <= pushData;
   end

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_unit
//  Description : Decoupled RV32I fetch stage with prefetch FIFO and redirect.
//                Optional macro FETCH_PERF_EN adds the stall_cycles counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit
   import klp32_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MAX_OUTST = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [XLEN-1:0]  imem_req_addr,
   input  logic             imem_rsp_valid,
   input  logic [ILEN-1:0]  imem_rsp_data,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [ILEN-1:0]  inst_data,
   output logic [XLEN-1:0]  inst_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]      stall_cycles
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int KW = $clog2(MAX_OUTST + 1);

   fetch_state_t     r_state;
   word_t            r_fetchPc;
   logic [KW-1:0]    r_kill;
   logic [KW-1:0]    w_killNext;
   logic [CW-1:0]    w_count;
   logic             w_fifoFull;
   logic             w_fifoEmpty;
   fetch_entry_t     w_head;
   fetch_entry_t     w_pushEntry;
   logic [KW-1:0]    w_pcqCount;
   logic             w_pcqFull;
   logic             w_pcqEmpty;
   word_t            w_rspPc;
   word_t            w_outst;
   logic             w_reqValid;
   logic             w_reqFire;
   logic             w_push;
   logic             w_pop;

   // Outstanding = live requests tracked in the PC queue plus stale ones still to be killed
   assign w_outst    = 32'(w_pcqCount) + 32'(r_kill);
   assign w_reqValid = (r_state != FS_RESET) && !redirect_valid && !w_pcqFull && !w_fifoFull &&
                       (w_outst < 32'(MAX_OUTST)) && ((32'(w_count) + w_outst) < 32'(DEPTH));
   assign w_reqFire  = w_reqValid && imem_req_ready;
   assign w_push     = imem_rsp_valid && !redirect_valid && (r_state != FS_FLUSH) && !w_pcqEmpty;
   assign w_pop      = !w_fifoEmpty && inst_ready && !redirect_valid;
   assign w_pushEntry = '{inst: imem_rsp_data, pc: w_rspPc};

   always_comb begin
      w_killNext = r_kill;
      if (redirect_valid)
         w_killNext = KW'(w_outst - 32'(imem_rsp_valid));
      else if (imem_rsp_valid && (r_state == FS_FLUSH))
         w_killNext = r_kill - KW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= FS_RESET;
         r_fetchPc <= RESET_PC;
         r_kill    <= '0;
      end else begin
         r_kill  <= w_killNext;
         r_state <= (w_killNext != '0) ? FS_FLUSH : FS_RUN;
         if (redirect_valid)  r_fetchPc <= redirect_pc & ~word_t'(3);
         else if (w_reqFire)  r_fetchPc <= r_fetchPc + PC_STEP;
      end
   end

   fetch_fifo #(.DEPTH(MAX_OUTST), .T(word_t)) u_pcQueue (
      .clk      (clk),
      .reset    (reset),
      .push     (w_reqFire),
      .pushData (r_fetchPc),
      .pop      (w_push),
      .flush    (redirect_valid),
      .popData  (w_rspPc),
      .count    (w_pcqCount),
      .full     (w_pcqFull),
      .empty    (w_pcqEmpty)
   );

   fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_prefetch (
      .clk      (clk),
      .reset    (reset),
      .push     (w_push),
      .pushData (w_pushEntry),
      .pop      (w_pop),
      .flush    (redirect_valid),
      .popData  (w_head),
      .count    (w_count),
      .full     (w_fifoFull),
      .empty    (w_fifoEmpty)
   );

   assign imem_req_valid = w_reqValid;
   assign imem_req_addr  = r_fetchPc;
   assign inst_valid     = !w_fifoEmpty;
   assign inst_data      = w_head.inst;
   assign inst_pc        = w_head.pc;

`ifdef FETCH_PERF_EN
   logic [31:0] r_stall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_stall <= '0;
      else if (inst_ready && w_fifoEmpty && (r_stall != 32'hFFFF_FFFF))
         r_stall <= r_stall + 32'd1;
   end

   assign stall_cycles = r_stall;
`endif

endmodule
`default_nettype wire
